// File: rtl/tft_panel_ctrl_if.sv
// Pixel-source request bus and panel pin bundle for the TFT panel controller.
// The master side is the controller: it issues x/y requests and drives the panel,
// the slave side is the frame source (and, in simulation, the panel observer).
interface tft_panel_ctrl_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          new_frame;
   logic [7:0]    pix_r;
   logic [7:0]    pix_g;
   logic [7:0]    pix_b;
   logic          tft_clk;
   logic          tft_hsync;
   logic          tft_vsync;
   logic          tft_data_ena;
   logic [7:0]    tft_red;
   logic [7:0]    tft_green;
   logic [7:0]    tft_blue;
   logic          tft_vdd;
   logic          tft_display;
   logic          tft_backlight;

   modport master (
      output x, y, new_frame,
      output tft_clk, tft_hsync, tft_vsync, tft_data_ena,
      output tft_red, tft_green, tft_blue,
      output tft_vdd, tft_display, tft_backlight,
      input  pix_r, pix_g, pix_b
   );

   modport slave (
      input  x, y, new_frame,
      input  tft_clk, tft_hsync, tft_vsync, tft_data_ena,
      input  tft_red, tft_green, tft_blue,
      input  tft_vdd, tft_display, tft_backlight,
      output pix_r, pix_g, pix_b
   );
endinterface

// File: rtl/tft_panel_ctrl.sv
// TFT panel controller: divided pixel clock, raster counters, one-pixel output
// pipeline with test patterns, frame-counted power sequencing, backlight PWM.
module tft_panel_ctrl #(
   parameter int H_ACTIVE   = 480,
   parameter int H_FP       = 2,
   parameter int H_SYNC     = 41,
   parameter int H_BP       = 2,
   parameter int V_ACTIVE   = 272,
   parameter int V_FP       = 2,
   parameter int V_SYNC     = 10,
   parameter int V_BP       = 2,
   parameter int XW         = 10,
   parameter int YW         = 9,
   parameter int CLK_DIV    = 4,
   parameter int PWR_FRAMES = 2,
   parameter int PWM_W      = 8
) (
   input  logic              cclk,
   input  logic              rstb,
   input  logic              power_down,
   input  logic [1:0]        test_mode,
   input  logic [31:0]       frequency_division,
   input  logic [PWM_W-1:0]  duty_cycle,
   tft_panel_ctrl_if.master  bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int FW      = (PWR_FRAMES > 1) ? $clog2(PWR_FRAMES) : 1;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
   localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [2:0] S_OFF      = 3'd0;
   localparam logic [2:0] S_VDD_ON   = 3'd1;
   localparam logic [2:0] S_DISP_ON  = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_BL_OFF   = 3'd4;
   localparam logic [2:0] S_DISP_OFF = 3'd5;

   logic [DW-1:0]    r_div;
   logic [XW-1:0]    r_x;
   logic [YW-1:0]    r_y;
   logic             r_new_frame;
   logic             r_de, r_hs, r_vs;
   logic [7:0]       r_red, r_green, r_blue;
   logic [2:0]       r_state;
   logic [FW-1:0]    r_frm_cnt;
   logic [31:0]      r_pre;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic [PWM_W-1:0] r_duty;
   logic             r_backlight;

   logic             w_pix_en, w_x_last, w_y_last, w_de, w_show, w_step_done, w_pwm_step, w_bl_go;
   logic [XW-1:0]    w_bar;
   logic [7:0]       w_red, w_green, w_blue;
   logic [2:0]       w_state_nxt;

   assign w_pix_en    = (r_div == DW'(CLK_DIV - 1));
   assign w_x_last    = (r_x == X_LAST);
   assign w_y_last    = (r_y == Y_LAST);
   assign w_de        = (r_x < X_ACT) && (r_y < Y_ACT);
   assign w_show      = (r_state == S_RUN) || (r_state == S_BL_OFF);
   assign w_bar       = r_x / XW'(BAR_W);
   assign w_step_done = r_new_frame && (r_frm_cnt == FW'(PWR_FRAMES - 1));
   assign w_pwm_step  = (r_pre >= frequency_division);
   assign w_bl_go     = (r_state == S_RUN) && !power_down;

   // Pixel clock divider and raster counters; x/y advance once per pixel period
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         r_div       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_new_frame <= 1'b0;
      end else begin
         r_div       <= w_pix_en ? '0 : r_div + 1'b1;
         r_new_frame <= w_pix_en && w_x_last && w_y_last;
         if (w_pix_en) begin
            if (w_x_last) begin
               r_x <= '0;
               r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
      end
   end

   // Pixel colour for the coordinate currently being requested
   always_comb begin
      w_red   = 8'd0;
      w_green = 8'd0;
      w_blue  = 8'd0;
      if (w_de && w_show) begin
         case (test_mode)
            2'd0: begin
               w_red   = bus.pix_r;
               w_green = bus.pix_g;
               w_blue  = bus.pix_b;
            end
            2'd1: begin
               if (w_bar < XW'(8)) begin
                  w_red   = {8{~w_bar[1]}};
                  w_green = {8{~w_bar[2]}};
                  w_blue  = {8{~w_bar[0]}};
               end
            end
            2'd2: begin
               w_red   = 8'(r_x);
               w_green = 8'(r_y);
            end
            default: begin
               w_red   = 8'hFF;
               w_green = 8'hFF;
               w_blue  = 8'hFF;
            end
         endcase
      end
   end

   // Panel pins registered for the pixel just requested, so they trail x/y by one pixel
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         r_de    <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_red   <= 8'd0;
         r_green <= 8'd0;
         r_blue  <= 8'd0;
      end else if (w_pix_en) begin
         r_de    <= w_de;
         r_hs    <= !((r_x >= HS_START) && (r_x < HS_END));
         r_vs    <= !((r_y >= VS_START) && (r_y < VS_END));
         r_red   <= w_red;
         r_green <= w_green;
         r_blue  <= w_blue;
      end
   end

   // Power sequencing next state; steps are paced by new_frame pulses
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_OFF:      if (!power_down) w_state_nxt = S_VDD_ON;
         S_VDD_ON:   if (power_down) w_state_nxt = S_DISP_OFF;
                     else if (w_step_done) w_state_nxt = S_DISP_ON;
         S_DISP_ON:  if (power_down) w_state_nxt = S_DISP_OFF;
                     else if (w_step_done) w_state_nxt = S_RUN;
         S_RUN:      if (power_down) w_state_nxt = S_BL_OFF;
         S_BL_OFF:   if (w_step_done) w_state_nxt = S_DISP_OFF;
         S_DISP_OFF: if (w_step_done) w_state_nxt = S_OFF;
         default:    w_state_nxt = S_OFF;
      endcase
   end

   // Power state register and frame counter, cleared whenever the state changes
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         r_state   <= S_OFF;
         r_frm_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state) r_frm_cnt <= '0;
         else if (r_new_frame)       r_frm_cnt <= r_frm_cnt + 1'b1;
      end
   end

   // Backlight PWM: prescaled step counter, duty taken only at period start
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         r_pre       <= '0;
         r_pwm_cnt   <= '0;
         r_duty      <= '0;
         r_backlight <= 1'b0;
      end else begin
         if (w_pwm_step) begin
            r_pre     <= '0;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (&r_pwm_cnt) r_duty <= duty_cycle;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
         r_backlight <= w_bl_go && (r_pwm_cnt < r_duty);
      end
   end

   assign bus.x             = r_x;
   assign bus.y             = r_y;
   assign bus.new_frame     = r_new_frame;
   assign bus.tft_clk       = (r_div >= DW'(CLK_DIV / 2));
   assign bus.tft_hsync     = r_hs;
   assign bus.tft_vsync     = r_vs;
   assign bus.tft_data_ena  = r_de;
   assign bus.tft_red       = r_red;
   assign bus.tft_green     = r_green;
   assign bus.tft_blue      = r_blue;
   assign bus.tft_vdd       = (r_state != S_OFF);
   assign bus.tft_display   = (r_state == S_DISP_ON) || (r_state == S_RUN) || (r_state == S_BL_OFF);
   assign bus.tft_backlight = r_backlight;
endmodule

// File: tb/tb_tft_panel_ctrl.sv
// Directed bench for tft_panel_ctrl on a small raster (12x7 totals, 2 cclk per pixel).
module tb_tft_panel_ctrl;
   logic        cclk = 1'b0;
   logic        rstb = 1'b1;
   logic        power_down = 1'b0;
   logic [1:0]  test_mode = 2'd2;
   logic [31:0] frequency_division = 32'd0;
   logic [7:0]  duty_cycle = 8'd64;

   int n_chk  = 0;
   int n_fail = 0;

   tft_panel_ctrl_if #(.XW(10), .YW(9)) bus ();

   // Upstream pixel source: a simple function of the requested coordinate
   assign bus.pix_r = {1'b0, bus.y[2:0], bus.x[3:0]};
   assign bus.pix_g = ~bus.pix_r;
   assign bus.pix_b = {bus.x[3:0], 4'h9};

   tft_panel_ctrl #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .XW(10), .YW(9), .CLK_DIV(2), .PWR_FRAMES(1), .PWM_W(8)
   ) dut (
      .cclk(cclk),
      .rstb(rstb),
      .power_down(power_down),
      .test_mode(test_mode),
      .frequency_division(frequency_division),
      .duty_cycle(duty_cycle),
      .bus(bus)
   );

   always #5 cclk = ~cclk;

   typedef struct packed {
      logic [1:0] mode;
      int         px;
      int         py;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       de;
      logic       hs;
      logic       vs;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_nf(input string name);
      int i;
      i = 0;
      @(negedge cclk);
      while (bus.new_frame !== 1'b1 && i < 400) begin
         @(negedge cclk);
         i++;
      end
      if (bus.new_frame !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: got no new_frame within 400 cycles expected a pulse", name);
      end
   endtask

   task automatic wait_rise(output bit ok);
      int   i;
      logic prev;
      i    = 0;
      prev = bus.tft_backlight;
      @(negedge cclk);
      while (!(bus.tft_backlight === 1'b1 && prev === 1'b0) && i < 700) begin
         prev = bus.tft_backlight;
         @(negedge cclk);
         i++;
      end
      ok = (bus.tft_backlight === 1'b1 && prev === 1'b0);
   endtask

   // Measures the high run of the backlight starting at the next rising edge
   task automatic measure_run(input int chg_at, input logic [7:0] nd, output int len);
      bit ok;
      wait_rise(ok);
      len = -1;
      if (ok) begin
         len = 0;
         while (bus.tft_backlight === 1'b1 && len < 600) begin
            len++;
            if (len == chg_at) duty_cycle = nd;
            @(negedge cclk);
         end
      end
   endtask

   initial begin
      int k, len, de_cnt, hs_cnt, vs_cnt, xmax, ymax, hi_cnt;
      bit ok;

      tbl[0]  = '{2'd2,  3, 2, 8'd3,   8'd2,   8'd0,   1'b1, 1'b1, 1'b1};
      tbl[1]  = '{2'd2,  7, 3, 8'd7,   8'd3,   8'd0,   1'b1, 1'b1, 1'b1};
      tbl[2]  = '{2'd2,  0, 0, 8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b1};
      tbl[3]  = '{2'd2,  8, 0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};
      tbl[4]  = '{2'd2,  9, 1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1};
      tbl[5]  = '{2'd2, 10, 2, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1};
      tbl[6]  = '{2'd2, 11, 2, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};
      tbl[7]  = '{2'd2,  0, 4, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};
      tbl[8]  = '{2'd2,  0, 5, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b0};
      tbl[9]  = '{2'd2,  9, 5, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0};
      tbl[10] = '{2'd2,  0, 6, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};
      tbl[11] = '{2'd1,  0, 0, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1};
      tbl[12] = '{2'd1,  1, 3, 8'd255, 8'd255, 8'd0,   1'b1, 1'b1, 1'b1};
      tbl[13] = '{2'd1,  2, 1, 8'd0,   8'd255, 8'd255, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{2'd1,  3, 0, 8'd0,   8'd255, 8'd0,   1'b1, 1'b1, 1'b1};
      tbl[15] = '{2'd1,  4, 2, 8'd255, 8'd0,   8'd255, 1'b1, 1'b1, 1'b1};
      tbl[16] = '{2'd1,  5, 3, 8'd255, 8'd0,   8'd0,   1'b1, 1'b1, 1'b1};
      tbl[17] = '{2'd1,  6, 0, 8'd0,   8'd0,   8'd255, 1'b1, 1'b1, 1'b1};
      tbl[18] = '{2'd1,  7, 2, 8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b1};
      tbl[19] = '{2'd3,  4, 1, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1};
      tbl[20] = '{2'd3,  8, 1, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};
      tbl[21] = '{2'd0,  2, 3, 8'h32,  8'hCD,  8'h29,  1'b1, 1'b1, 1'b1};
      tbl[22] = '{2'd0,  5, 1, 8'h15,  8'hEA,  8'h59,  1'b1, 1'b1, 1'b1};
      tbl[23] = '{2'd0, 11, 6, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b1};

      // Reset state
      #2 rstb = 1'b0;
      repeat (3) @(negedge cclk);
      chk("rst_xy", {bus.x, bus.y}, 0);
      chk("rst_sync", {bus.tft_hsync, bus.tft_vsync}, 2'b11);
      chk("rst_pins", {bus.new_frame, bus.tft_clk, bus.tft_data_ena, bus.tft_red, bus.tft_green,
                       bus.tft_blue, bus.tft_vdd, bus.tft_display, bus.tft_backlight}, 0);

      // Power-up sequence with cycle-exact timing from reset release
      rstb = 1'b1;
      k = 0;
      @(negedge cclk); k++;
      chk("tft_clk_k1", bus.tft_clk, 1'b1);
      chk("vdd_k1", {bus.tft_vdd, bus.tft_display}, 2'b10);
      @(negedge cclk); k++;
      chk("tft_clk_k2", bus.tft_clk, 1'b0);
      while (k < 400 && bus.new_frame !== 1'b1) begin @(negedge cclk); k++; end
      chk("nf_first_cycle", k, 168);
      @(negedge cclk); k++;
      chk("display_on", {bus.tft_vdd, bus.tft_display}, 2'b11);
      while (k < 224) begin @(negedge cclk); k++; end
      chk("blank_disp_on", {bus.tft_data_ena, bus.tft_red, bus.tft_green}, {1'b1, 16'h0});
      @(negedge cclk); k++;
      while (k < 600 && bus.new_frame !== 1'b1) begin @(negedge cclk); k++; end
      chk("nf_second_cycle", k, 336);
      while (k < 392) begin @(negedge cclk); k++; end
      chk("run_grad_3_2", {bus.tft_data_ena, bus.tft_red, bus.tft_green, bus.tft_blue},
          {1'b1, 8'd3, 8'd2, 8'd0});

      // Table of panel pixels per test mode, sampled one pixel after request
      for (int i = 0; i < NV; i++) begin
         wait_nf($sformatf("vec%0d_sync", i));
         test_mode = tbl[i].mode;
         repeat (2 * (tbl[i].py * 12 + tbl[i].px) + 2) @(negedge cclk);
         chk($sformatf("vec%0d_m%0d_x%0d_y%0d", i, tbl[i].mode, tbl[i].px, tbl[i].py),
             {bus.tft_red, bus.tft_green, bus.tft_blue, bus.tft_data_ena, bus.tft_hsync, bus.tft_vsync},
             {tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de, tbl[i].hs, tbl[i].vs});
      end

      // Whole-frame timing statistics
      wait_nf("stats_sync");
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; xmax = 0; ymax = 0;
      for (int i = 0; i < 168; i++) begin
         @(negedge cclk);
         if (bus.tft_data_ena === 1'b1) de_cnt++;
         if (bus.tft_hsync === 1'b0) hs_cnt++;
         if (bus.tft_vsync === 1'b0) vs_cnt++;
         if (int'(bus.x) > xmax) xmax = int'(bus.x);
         if (int'(bus.y) > ymax) ymax = int'(bus.y);
      end
      chk("de_samples", de_cnt, 64);
      chk("hsync_low_samples", hs_cnt, 28);
      chk("vsync_low_samples", vs_cnt, 24);
      chk("x_max", xmax, 11);
      chk("y_max", ymax, 6);

      // Backlight PWM in RUN
      measure_run(0, 8'd0, len);
      chk("pwm_run_64", len, 64);
      measure_run(5, 8'd128, len);
      chk("pwm_change_midperiod", len, 64);
      measure_run(0, 8'd0, len);
      chk("pwm_run_128", len, 128);
      duty_cycle = 8'd255;
      repeat (260) @(negedge cclk);
      measure_run(0, 8'd0, len);
      chk("pwm_run_255", len, 255);
      duty_cycle = 8'd0;
      repeat (260) @(negedge cclk);
      hi_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge cclk);
         if (bus.tft_backlight === 1'b1) hi_cnt++;
      end
      chk("pwm_duty0", hi_cnt, 0);

      // Power-down sequence from RUN with the backlight on
      duty_cycle = 8'd255;
      repeat (260) @(negedge cclk);
      wait_rise(ok);
      chk("pd_bl_rise", ok, 1'b1);
      repeat (4) @(negedge cclk);
      power_down = 1'b1;
      @(negedge cclk);
      chk("pd_bl_off", {bus.tft_backlight, bus.tft_display, bus.tft_vdd}, 3'b011);
      wait_nf("pd_nf1");
      @(negedge cclk);
      chk("pd_disp_off", {bus.tft_display, bus.tft_vdd}, 2'b01);
      wait_nf("pd_nf2");
      @(negedge cclk);
      chk("pd_vdd_off", {bus.tft_display, bus.tft_vdd}, 2'b00);
      wait_nf("off_sync");
      test_mode = 2'd3;
      repeat (2 * (1 * 12 + 3) + 2) @(negedge cclk);
      chk("off_rgb_blank", {bus.tft_data_ena, bus.tft_red, bus.tft_green, bus.tft_blue}, {1'b1, 24'h0});
      power_down = 1'b0;
      @(negedge cclk);
      chk("restart_vdd", bus.tft_vdd, 1'b1);

      // Asynchronous reset in the middle of a line, inside the hsync pulse
      wait_nf("rst_sync");
      repeat (20) @(negedge cclk);
      chk("mid_hsync_low", bus.tft_hsync, 1'b0);
      rstb = 1'b0;
      #1;
      chk("mid_rst_xy", {bus.x, bus.y}, 0);
      chk("mid_rst_sync", {bus.tft_hsync, bus.tft_vsync}, 2'b11);
      chk("mid_rst_pins", {bus.new_frame, bus.tft_clk, bus.tft_data_ena, bus.tft_red, bus.tft_green,
                           bus.tft_blue, bus.tft_vdd, bus.tft_display, bus.tft_backlight}, 0);
      @(negedge cclk);
      rstb = 1'b1;
      @(negedge cclk);
      chk("post_rst_clk_vdd", {bus.tft_clk, bus.tft_vdd}, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
